// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_reg
//  Purpose  : ID/EX pipeline register of the 5-stage MIPS core. Captures the
//             decoded controls and operands from ID, resolves the EX
//             destination register and raises a load-use hazard request.
//  Ports    : clk, rst (sync, active-low)
//             stall_in  - hold all contents
//             flush_in  - replace the ID instruction with a bubble
//             id_*      - decoder controls / operands / instruction fields
//             ex_*      - registered copies of id_* (plus ex_valid, ex_wreg)
//             hazard_stall - combinational load-use stall request
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_reg #(
  parameter int DW = 32,
  parameter int RA = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_in,
  input  logic          flush_in,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic [4:0]    id_shamt,
  input  logic [5:0]    id_funct,
  input  logic          id_load,
  input  logic          id_shamt_sel,
  input  logic          id_alu_sel,
  input  logic          id_dm_wr,
  input  logic          id_rf_wr,
  input  logic [2:0]    id_ext_mem,
  input  logic [1:0]    id_dm_choose,
  input  logic [1:0]    id_alu_op,
  input  logic [1:0]    id_reg_dst,
  input  logic [1:0]    id_rf_data_sel,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [4:0]    ex_shamt,
  output logic [5:0]    ex_funct,
  output logic          ex_load,
  output logic          ex_shamt_sel,
  output logic          ex_alu_sel,
  output logic          ex_dm_wr,
  output logic          ex_rf_wr,
  output logic [2:0]    ex_ext_mem,
  output logic [1:0]    ex_dm_choose,
  output logic [1:0]    ex_alu_op,
  output logic [1:0]    ex_reg_dst,
  output logic [1:0]    ex_rf_data_sel,
  output logic          ex_valid,
  output logic [4:0]    ex_wreg,
  output logic          hazard_stall
);

  localparam logic [1:0] c_dst_ra   = 2'b00;
  localparam logic [1:0] c_dst_rd   = 2'b01;
  localparam logic [1:0] c_dst_rt   = 2'b10;
  localparam logic [4:0] c_ra_index = 5'(RA);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [4:0]    wreg;
    logic [5:0]    funct;
    logic          load;
    logic          shamt_sel;
    logic          alu_sel;
    logic          dm_wr;
    logic          rf_wr;
    logic [2:0]    ext_mem;
    logic [1:0]    dm_choose;
    logic [1:0]    alu_op;
    logic [1:0]    reg_dst;
    logic [1:0]    rf_data_sel;
  } ex_stage_t;

  ex_stage_t ex_d, ex_q;
  logic [4:0] wreg_d;

  // Destination resolved in ID so EX sees a ready register index.
  always_comb begin
    wreg_d = 5'd0;
    case (id_reg_dst)
      c_dst_ra: wreg_d = c_ra_index;
      c_dst_rd: wreg_d = id_rd;
      c_dst_rt: wreg_d = id_rt;
      default:  wreg_d = 5'd0;
    endcase
  end

  // A load whose target is read by the ID instruction. $0 is never a
  // dependence; rt is compared even when the instruction does not use it.
  assign hazard_stall = id_valid & ex_q.valid & ex_q.load & (ex_q.wreg != 5'd0) &
                        ((ex_q.wreg == id_rs) | (ex_q.wreg == id_rt));

  always_comb begin
    ex_d = ex_q;
    if (!stall_in) begin
      if (flush_in || hazard_stall) begin
        ex_d = '0;
      end else begin
        ex_d.valid       = id_valid;
        ex_d.pc          = id_pc;
        ex_d.rs_data     = id_rs_data;
        ex_d.rt_data     = id_rt_data;
        ex_d.imm         = id_imm;
        ex_d.rs          = id_rs;
        ex_d.rt          = id_rt;
        ex_d.rd          = id_rd;
        ex_d.shamt       = id_shamt;
        ex_d.wreg        = wreg_d;
        ex_d.funct       = id_funct;
        // Side-effecting controls only survive for a real instruction.
        ex_d.load        = id_load  & id_valid;
        ex_d.dm_wr       = id_dm_wr & id_valid;
        ex_d.rf_wr       = id_rf_wr & id_valid;
        ex_d.shamt_sel   = id_shamt_sel;
        ex_d.alu_sel     = id_alu_sel;
        ex_d.ext_mem     = id_ext_mem;
        ex_d.dm_choose   = id_dm_choose;
        ex_d.alu_op      = id_alu_op;
        ex_d.reg_dst     = id_reg_dst;
        ex_d.rf_data_sel = id_rf_data_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid       = ex_q.valid;
  assign ex_pc          = ex_q.pc;
  assign ex_rs_data     = ex_q.rs_data;
  assign ex_rt_data     = ex_q.rt_data;
  assign ex_imm         = ex_q.imm;
  assign ex_rs          = ex_q.rs;
  assign ex_rt          = ex_q.rt;
  assign ex_rd          = ex_q.rd;
  assign ex_shamt       = ex_q.shamt;
  assign ex_wreg        = ex_q.wreg;
  assign ex_funct       = ex_q.funct;
  assign ex_load        = ex_q.load;
  assign ex_shamt_sel   = ex_q.shamt_sel;
  assign ex_alu_sel     = ex_q.alu_sel;
  assign ex_dm_wr       = ex_q.dm_wr;
  assign ex_rf_wr       = ex_q.rf_wr;
  assign ex_ext_mem     = ex_q.ext_mem;
  assign ex_dm_choose   = ex_q.dm_choose;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_reg_dst     = ex_q.reg_dst;
  assign ex_rf_data_sel = ex_q.rf_data_sel;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_reg
//  Purpose  : Directed self-checking bench for id_ex_reg.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, stall_in, flush_in, id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_funct;
  logic        id_load, id_shamt_sel, id_alu_sel, id_dm_wr, id_rf_wr;
  logic [2:0]  id_ext_mem;
  logic [1:0]  id_dm_choose, id_alu_op, id_reg_dst, id_rf_data_sel;

  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt, ex_wreg;
  logic [5:0]  ex_funct;
  logic        ex_load, ex_shamt_sel, ex_alu_sel, ex_dm_wr, ex_rf_wr, ex_valid;
  logic [2:0]  ex_ext_mem;
  logic [1:0]  ex_dm_choose, ex_alu_op, ex_reg_dst, ex_rf_data_sel;
  logic        hazard_stall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DW(32), .RA(31)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
    .id_load(id_load), .id_shamt_sel(id_shamt_sel), .id_alu_sel(id_alu_sel),
    .id_dm_wr(id_dm_wr), .id_rf_wr(id_rf_wr), .id_ext_mem(id_ext_mem),
    .id_dm_choose(id_dm_choose), .id_alu_op(id_alu_op),
    .id_reg_dst(id_reg_dst), .id_rf_data_sel(id_rf_data_sel),
    .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_load(ex_load),
    .ex_shamt_sel(ex_shamt_sel), .ex_alu_sel(ex_alu_sel),
    .ex_dm_wr(ex_dm_wr), .ex_rf_wr(ex_rf_wr), .ex_ext_mem(ex_ext_mem),
    .ex_dm_choose(ex_dm_choose), .ex_alu_op(ex_alu_op),
    .ex_reg_dst(ex_reg_dst), .ex_rf_data_sel(ex_rf_data_sel),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .hazard_stall(hazard_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc,
                           input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [1:0] dst,
                           input logic ld, input logic rfw, input logic dmw);
    id_valid = v;  id_pc = pc;  id_rs = rs;  id_rt = rt;  id_rd = rd;
    id_reg_dst = dst;  id_load = ld;  id_rf_wr = rfw;  id_dm_wr = dmw;
  endtask

  initial begin
    rst = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0; id_funct = '0;
    id_shamt_sel = 1'b0; id_alu_sel = 1'b0; id_ext_mem = '0; id_dm_choose = '0;
    id_alu_op = '0; id_rf_data_sel = '0;
    set_instr(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 2'b01, 1'b0, 1'b1, 1'b0);

    // Reset with live ID inputs
    step(); step();
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_rf_wr", 64'(ex_rf_wr), 64'd0);
    check("rst_wreg", 64'(ex_wreg), 64'd0);
    check("rst_hazard", 64'(hazard_stall), 64'd0);
    rst = 1'b1;

    // addu $10,$8,$9
    set_instr(1'b1, 32'h104, 5'd8, 5'd9, 5'd10, 2'b01, 1'b0, 1'b1, 1'b0);
    id_rs_data = 32'h11; id_rt_data = 32'h22; id_funct = 6'h21;
    step();
    check("addu_wreg", 64'(ex_wreg), 64'd10);
    check("addu_rs_data", 64'(ex_rs_data), 64'h11);
    check("addu_rt_data", 64'(ex_rt_data), 64'h22);
    check("addu_valid", 64'(ex_valid), 64'd1);
    check("addu_funct", 64'(ex_funct), 64'h21);

    // jal links to $31
    set_instr(1'b1, 32'h400, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    check("jal_wreg", 64'(ex_wreg), 64'd31);
    check("jal_pc", 64'(ex_pc), 64'h400);

    // lw $9 then dependent add
    set_instr(1'b1, 32'h408, 5'd8, 5'd9, 5'd0, 2'b10, 1'b1, 1'b1, 1'b0);
    id_ext_mem = 3'b100; id_imm = 32'h0000_0010;
    step();
    check("lw_wreg", 64'(ex_wreg), 64'd9);
    check("lw_load", 64'(ex_load), 64'd1);
    check("lw_ext_mem", 64'(ex_ext_mem), 64'd4);
    set_instr(1'b1, 32'h40c, 5'd9, 5'd3, 5'd11, 2'b01, 1'b0, 1'b1, 1'b0);
    id_ext_mem = 3'b000;
    #1;
    check("lu_hazard_on", 64'(hazard_stall), 64'd1);
    step();
    check("lu_bubble_valid", 64'(ex_valid), 64'd0);
    check("lu_bubble_rf_wr", 64'(ex_rf_wr), 64'd0);
    check("lu_bubble_wreg", 64'(ex_wreg), 64'd0);
    check("lu_hazard_off", 64'(hazard_stall), 64'd0);
    step();
    check("lu_add_wreg", 64'(ex_wreg), 64'd11);
    check("lu_add_valid", 64'(ex_valid), 64'd1);
    check("lu_add_pc", 64'(ex_pc), 64'h40c);

    // lw $0 never stalls
    set_instr(1'b1, 32'h410, 5'd8, 5'd0, 5'd0, 2'b10, 1'b1, 1'b1, 1'b0);
    step();
    set_instr(1'b1, 32'h414, 5'd0, 5'd0, 5'd11, 2'b01, 1'b0, 1'b1, 1'b0);
    #1;
    check("lw0_no_hazard", 64'(hazard_stall), 64'd0);
    step();
    check("lw0_next_loaded", 64'(ex_pc), 64'h414);

    // Hold for 3 cycles with changing ID
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, 32'h600 + 32'(i), 5'd4, 5'd5, 5'(20 + i), 2'b01, 1'b0, 1'b1, 1'b0);
      id_rs_data = 32'(i);
      step();
      check("hold_pc", 64'(ex_pc), 64'h414);
      check("hold_wreg", 64'(ex_wreg), 64'd11);
    end
    stall_in = 1'b0;
    set_instr(1'b1, 32'h500, 5'd4, 5'd5, 5'd12, 2'b01, 1'b0, 1'b1, 1'b0);
    step();
    check("hold_release_pc", 64'(ex_pc), 64'h500);
    check("hold_release_wreg", 64'(ex_wreg), 64'd12);

    // Flush a sw
    set_instr(1'b1, 32'h504, 5'd4, 5'd5, 5'd0, 2'b11, 1'b0, 1'b0, 1'b1);
    id_dm_choose = 2'b10;
    flush_in = 1'b1;
    step();
    check("flush_dm_wr", 64'(ex_dm_wr), 64'd0);
    check("flush_valid", 64'(ex_valid), 64'd0);
    check("flush_dm_choose", 64'(ex_dm_choose), 64'd0);
    flush_in = 1'b0;
    step();
    check("sw_dm_wr", 64'(ex_dm_wr), 64'd1);
    check("sw_dm_choose", 64'(ex_dm_choose), 64'd2);
    check("sw_wreg_dst11", 64'(ex_wreg), 64'd0);
    flush_in = 1'b1; stall_in = 1'b1;
    step();
    check("flush_stall_dm_wr", 64'(ex_dm_wr), 64'd1);
    check("flush_stall_valid", 64'(ex_valid), 64'd1);
    flush_in = 1'b0; stall_in = 1'b0;

    // Load of an invalid slot drops side effects
    set_instr(1'b0, 32'h508, 5'd1, 5'd2, 5'd3, 2'b01, 1'b1, 1'b1, 1'b1);
    id_imm = 32'hdead_beef;
    step();
    check("inv_valid", 64'(ex_valid), 64'd0);
    check("inv_rf_wr", 64'(ex_rf_wr), 64'd0);
    check("inv_dm_wr", 64'(ex_dm_wr), 64'd0);
    check("inv_load", 64'(ex_load), 64'd0);
    check("inv_imm", 64'(ex_imm), 64'hdead_beef);

    // Hazard held across stall_in, via rt compare
    set_instr(1'b1, 32'h50c, 5'd8, 5'd7, 5'd0, 2'b10, 1'b1, 1'b1, 1'b0);
    step();
    set_instr(1'b1, 32'h510, 5'd1, 5'd7, 5'd13, 2'b01, 1'b0, 1'b1, 1'b0);
    stall_in = 1'b1;
    #1;
    check("stall_hz_on", 64'(hazard_stall), 64'd1);
    step();
    check("stall_hz_held", 64'(hazard_stall), 64'd1);
    check("stall_hz_load", 64'(ex_load), 64'd1);
    stall_in = 1'b0;
    step();
    check("stall_hz_bubble", 64'(ex_valid), 64'd0);
    step();
    check("stall_hz_add", 64'(ex_wreg), 64'd13);

    // Reset while a hazard is pending
    set_instr(1'b1, 32'h514, 5'd8, 5'd6, 5'd0, 2'b10, 1'b1, 1'b1, 1'b0);
    step();
    set_instr(1'b1, 32'h518, 5'd6, 5'd2, 5'd14, 2'b01, 1'b0, 1'b1, 1'b0);
    #1;
    check("rh_hazard_pre", 64'(hazard_stall), 64'd1);
    rst = 1'b0;
    step();
    check("rh_load", 64'(ex_load), 64'd0);
    check("rh_hazard", 64'(hazard_stall), 64'd0);
    check("rh_valid", 64'(ex_valid), 64'd0);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core. It sits directly downstream of the ID-stage main decoder and the register file.
- Captures decoded control signals and operands each cycle and presents them to the EX stage.
- Resolves the EX destination register and detects load-use hazards.
- Supports hold on stall_in, squash on flush_in, and bubble insertion on a load-use hazard.

Parameters:
- DW, 32, datapath width (PC, operands, immediate)
- RA, 31, link register index for jal (RegDst=00)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (rst=0 resets on next rising edge)
- stall_in  in  1  downstream hold; register keeps contents
- flush_in  in  1  squash ID instruction (branch/jump redirect)
- id_valid  in  1  ID stage holds a real instruction
- id_pc  in  DW  PC of ID instruction (jal/jalr link source)
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  extended immediate (extension done in ID per EXTOp)
- id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction fields
- id_funct  in  6  funct field for ALU secondary decode
- id_load, id_shamt_sel, id_alu_sel, id_dm_wr, id_rf_wr  in  1 each  decoder controls
- id_ext_mem  in  3  load extension type (000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw)
- id_dm_choose  in  2  store width (00 sb, 01 sh, 10 sw)
- id_alu_op, id_reg_dst, id_rf_data_sel  in  2 each  decoder controls
- ex_*  out  (same widths)  registered copies of every id_* input above except id_valid
- ex_valid  out  1  EX holds a real instruction
- ex_wreg  out  5  resolved destination: RegDst 00 -> RA, 01 -> ex_rd, 10 -> ex_rt, 11 -> 0
- hazard_stall  out  1  load-use stall request to PC/IF-ID (combinational)

Behaviour:
- Reset (rst=0 at edge): every ex_* output and ex_valid = 0; ex_wreg = 0. Reset has highest priority.
- Update priority per edge, when rst=1:
  - stall_in=1: hold all registers; flush_in and hazard ignored that edge.
  - else flush_in=1: load bubble.
  - else hazard_stall=1: load bubble.
  - else load all id_* inputs and set ex_valid = id_valid.
- Bubble:
  - ex_valid, ex_rf_wr, ex_dm_wr and ex_load are 0.
  - All other ex_* outputs are 0 as well, for deterministic waveforms.
- Loading with id_valid=0 also forces ex_rf_wr, ex_dm_wr and ex_load to 0.
- Latency: inputs appear on ex_* 1 cycle after a loading edge.
- ex_wreg is registered, computed from id_reg_dst/id_rd/id_rt at the loading edge, and held or bubbled with the rest.
- hazard_stall = id_valid & ex_valid & ex_load & (ex_wreg != 0) & ((ex_wreg == id_rs) | (ex_wreg == id_rt)).
  - The comparison is conservative: rt is compared even for I-type instructions that do not read it.
- Hazard duration: exactly 1 cycle. The bubble clears ex_load, so hazard_stall drops the next cycle unless stall_in holds EX.
- While stall_in=1 with a hazard pending, hazard_stall stays asserted. The upstream stage must hold in either case.
- flush_in and hazard_stall together: a bubble is inserted, and the ID instruction is discarded by the upstream flush.
- Register $0 is never a hazard source, and ex_wreg=0 never stalls.
- Mid-operation reset clears ex_valid and the pending hazard on the same edge; no partial state survives.

Test Plan:
- Reset: drive id_rf_wr=1, id_valid=1, rst=0 for 2 cycles -> ex_valid=0, ex_rf_wr=0, ex_wreg=0, hazard_stall=0.
- Pass-through: addu with id_rs=8, id_rt=9, id_rd=10, id_reg_dst=01, id_rs_data=32'h11, id_rt_data=32'h22 -> next cycle ex_wreg=10, ex_rs_data=32'h11, ex_rt_data=32'h22, ex_valid=1. Also drive jal (reg_dst=00) -> ex_wreg=31.
- Load-use: lw to $9 (id_reg_dst=10, id_rt=9) loaded, then ID add with id_rs=9 -> hazard_stall=1 for exactly 1 cycle, followed by an EX bubble (ex_valid=0, ex_rf_wr=0). Then the add loads. Same lw to $0 -> no stall.
- Hold: assert stall_in for 3 cycles with changing id_* -> ex_* unchanged throughout, then the next id_* loads when stall_in drops.
- Flush: flush_in=1 with a sw in ID (id_dm_wr=1) -> next cycle ex_dm_wr=0, ex_valid=0. Flush together with stall_in -> contents held.
- Reset mid-hazard: lw in EX with a dependent instruction in ID, rst=0 for 1 cycle -> ex_load=0, hazard_stall=0 on the following cycle.
